udp_stream_generator: RTL

//  Parametrised UDP transmit traffic source: emits framed UDP packets (header + payload) into the
//  udp_complete_wrapper input side (udp_header_interface Input / axis Sink fields, flattened here).

---
 rtl/udp_gen_pkg.sv | 31 +++
 rtl/udp_gen_pattern.sv | 51 +++++
 rtl/udp_stream_generator.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_gen_pkg.sv
// udp_gen_pkg: shared state/pattern types, header constants and length clamp for the UDP generator.
package udp_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } gen_state_t;

  typedef enum logic {
    PAT_INCR  = 1'b0,
    PAT_CONST = 1'b1
  } pattern_mode_t;

  localparam int unsigned UDP_HDR_BYTES = 8;

  localparam logic [31:0] DEFAULT_SRC_IP   = 32'hC0A8_010A;
  localparam logic [31:0] DEFAULT_DST_IP   = 32'hC0A8_0164;
  localparam logic [15:0] DEFAULT_SRC_PORT = 16'd5000;
  localparam logic [15:0] DEFAULT_DST_PORT = 16'd5001;
  localparam logic [7:0]  DEFAULT_TTL      = 8'd64;

  // Payload length actually sent: at least one byte, at most max_len bytes.
  function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] max_len);
    if (len == 16'd0) return 16'd1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/udp_gen_pattern.sv
// udp_gen_pattern: combinational byte-lane pattern and tkeep/tlast generator for one payload beat.
// With UDP_GEN_SEQ_NUM_EN defined, payload bytes 0..3 carry seq_num big-endian.
module udp_gen_pattern
  import udp_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [15:0]             byte_off,
  input  logic [15:0]             len,
  input  pattern_mode_t           mode,
  input  logic [7:0]              seed,
  input  logic [31:0]             seq_num,
  output logic [DATA_WIDTH-1:0]   tdata_c,
  output logic [DATA_WIDTH/8-1:0] tkeep_c,
  output logic                    tlast_c
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic [16:0] remain;

`ifndef UDP_GEN_SEQ_NUM_EN
  logic unused_seq;
  assign unused_seq = ^seq_num;
`endif

  // Fill each lane that still holds payload; lanes past the end stay zero.
  always_comb begin
    tdata_c = '0;
    tkeep_c = '0;
    remain  = {1'b0, len} - {1'b0, byte_off};
    tlast_c = (remain <= 17'(KEEP_WIDTH));
    for (int unsigned j = 0; j < KEEP_WIDTH; j++) begin
      if (17'(j) < remain) begin
        tkeep_c[j] = 1'b1;
        tdata_c[8*j +: 8] = (mode == PAT_INCR) ? (seed + byte_off[7:0] + 8'(j)) : seed;
`ifdef UDP_GEN_SEQ_NUM_EN
        if ((byte_off + 16'(j)) < 16'd4) begin
          case (2'(byte_off + 16'(j)))
            2'd0:    tdata_c[8*j +: 8] = seq_num[31:24];
            2'd1:    tdata_c[8*j +: 8] = seq_num[23:16];
            2'd2:    tdata_c[8*j +: 8] = seq_num[15:8];
            default: tdata_c[8*j +: 8] = seq_num[7:0];
          endcase
        end
`endif
      end
    end
  end

endmodule

// File: rtl/udp_stream_generator.sv
// udp_stream_generator: framed UDP transmit traffic source (header handshake, then payload beats,
// then an idle gap), with runtime length/count/gap/pattern. Optional macro UDP_GEN_SEQ_NUM_EN
// puts the packet sequence number in payload bytes 0..3.
module udp_stream_generator
  import udp_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned MAX_PAYLOAD_BYTES = 1472,
  parameter int unsigned GAP_WIDTH         = 16
) (
  input  logic                    udp_sys_clk,
  input  logic                    system_reset_n,
  input  logic                    enable,
  input  logic [15:0]             cfg_payload_len,
  input  logic [31:0]             cfg_pkt_count,
  input  logic [GAP_WIDTH-1:0]    cfg_gap_cycles,
  input  logic                    cfg_pattern_mode,
  input  logic [7:0]              cfg_pattern_seed,
  input  logic [31:0]             cfg_src_ip,
  input  logic [31:0]             cfg_dst_ip,
  input  logic [15:0]             cfg_src_port,
  input  logic [15:0]             cfg_dst_port,
  input  logic [7:0]              cfg_ttl,
  output logic                    udp_hdr_valid,
  input  logic                    udp_hdr_ready,
  output logic [31:0]             udp_ip_source_ip,
  output logic [31:0]             udp_ip_dest_ip,
  output logic [15:0]             udp_source_port,
  output logic [15:0]             udp_dest_port,
  output logic [15:0]             udp_length,
  output logic [15:0]             udp_checksum,
  output logic [7:0]              udp_ip_ttl,
  output logic [5:0]              udp_ip_dscp,
  output logic [1:0]              udp_ip_ecn,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             pkts_sent
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam logic [15:0] BEAT_BYTES = 16'(KEEP_WIDTH);
  localparam logic [15:0] MAX_LEN    = 16'(MAX_PAYLOAD_BYTES);

  gen_state_t             state_q, state_d;
  logic                   hdr_valid_q, hdr_valid_d;
  logic [31:0]            src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [15:0]            src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic [15:0]            udp_len_q, udp_len_d;
  logic [7:0]             ttl_q, ttl_d;
  logic [15:0]            len_q, len_d;
  pattern_mode_t          mode_q, mode_d;
  logic [7:0]             seed_q, seed_d;
  logic [31:0]            count_q, count_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [15:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   run_cplt_q, run_cplt_d;
  logic [31:0]            pkts_sent_q, pkts_sent_d;

  logic [15:0]            pat_off;
  logic [DATA_WIDTH-1:0]  pat_data;
  logic [KEEP_WIDTH-1:0]  pat_keep;
  logic                   pat_last;
  logic [31:0]            pkts_inc;
  logic                   count_hit, more_pkts, start_pkt, load_beat;
  logic [15:0]            cfg_len;

  // Beat 0 starts at offset 0; later beats advance by one beat of bytes.
  assign pat_off = (state_q == HDR) ? 16'd0 : off_q + BEAT_BYTES;
  assign cfg_len = clamp_len(cfg_payload_len, MAX_LEN);

  udp_gen_pattern #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern (
    .byte_off (pat_off),
    .len      (len_q),
    .mode     (mode_q),
    .seed     (seed_q),
    .seq_num  (pkts_sent_q),
    .tdata_c  (pat_data),
    .tkeep_c  (pat_keep),
    .tlast_c  (pat_last)
  );

  // Next-state and next-output logic for the IDLE/HDR/PAYLOAD/GAP sequencer.
  always_comb begin
    state_d     = state_q;
    hdr_valid_d = hdr_valid_q;
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    src_port_d  = src_port_q;
    dst_port_d  = dst_port_q;
    udp_len_d   = udp_len_q;
    ttl_d       = ttl_q;
    len_d       = len_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    count_d     = count_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    off_d       = off_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pkts_sent_d = pkts_sent_q;
    done_d      = 1'b0;
    run_cplt_d  = run_cplt_q & enable;
    start_pkt   = 1'b0;
    load_beat   = 1'b0;
    pkts_inc    = pkts_sent_q + 32'd1;
    count_hit   = (count_q != 32'd0) && (pkts_inc == count_q);
    more_pkts   = enable && ((count_q == 32'd0) || (pkts_sent_q != count_q));

    case (state_q)
      IDLE: begin
        if (enable && !run_cplt_q) begin
          state_d     = HDR;
          start_pkt   = 1'b1;
          pkts_sent_d = 32'd0;
        end
      end
      HDR: begin
        if (hdr_valid_q && udp_hdr_ready) begin
          state_d     = PAYLOAD;
          hdr_valid_d = 1'b0;
          load_beat   = 1'b1;
        end
      end
      PAYLOAD: begin
        if (tvalid_q && m_tready) begin
          if (tlast_q) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            tdata_d     = '0;
            tkeep_d     = '0;
            pkts_sent_d = pkts_inc;
            if (count_hit) begin
              done_d     = 1'b1;
              run_cplt_d = 1'b1;
            end
            if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end else if (enable && !count_hit) begin
              state_d   = HDR;
              start_pkt = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_WIDTH'(1)) begin
          if (more_pkts) begin
            state_d   = HDR;
            start_pkt = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = pat_data;
      tkeep_d  = pat_keep;
      tlast_d  = pat_last;
      off_d    = pat_off;
    end

    // Configuration is captured once per packet and held until the next header.
    if (start_pkt) begin
      hdr_valid_d = 1'b1;
      src_ip_d    = cfg_src_ip;
      dst_ip_d    = cfg_dst_ip;
      src_port_d  = cfg_src_port;
      dst_port_d  = cfg_dst_port;
      ttl_d       = cfg_ttl;
      len_d       = cfg_len;
      udp_len_d   = cfg_len + 16'(UDP_HDR_BYTES);
      mode_d      = pattern_mode_t'(cfg_pattern_mode);
      seed_d      = cfg_pattern_seed;
      count_d     = cfg_pkt_count;
      gap_d       = cfg_gap_cycles;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge udp_sys_clk) begin
    if (!system_reset_n) begin
      state_q     <= IDLE;
      hdr_valid_q <= 1'b0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      udp_len_q   <= '0;
      ttl_q       <= '0;
      len_q       <= '0;
      mode_q      <= PAT_INCR;
      seed_q      <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      off_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      run_cplt_q  <= 1'b0;
      pkts_sent_q <= '0;
    end else begin
      state_q     <= state_d;
      hdr_valid_q <= hdr_valid_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      udp_len_q   <= udp_len_d;
      ttl_q       <= ttl_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      off_q       <= off_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      run_cplt_q  <= run_cplt_d;
      pkts_sent_q <= pkts_sent_d;
    end
  end

  assign udp_hdr_valid    = hdr_valid_q;
  assign udp_ip_source_ip = src_ip_q;
  assign udp_ip_dest_ip   = dst_ip_q;
  assign udp_source_port  = src_port_q;
  assign udp_dest_port    = dst_port_q;
  assign udp_length       = udp_len_q;
  assign udp_checksum     = 16'd0;
  assign udp_ip_ttl       = ttl_q;
  assign udp_ip_dscp      = 6'd0;
  assign udp_ip_ecn       = 2'd0;
  assign m_tdata          = tdata_q;
  assign m_tkeep          = tkeep_q;
  assign m_tvalid         = tvalid_q;
  assign m_tlast          = tlast_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pkts_sent        = pkts_sent_q;

endmodule
